next_line_prefetcher: RTL

//  Prefetch engine feeding the prefetch cache. On a demand-miss trigger it reads the next
//  PF_DEGREE sequential cachelines from pmem through its own cacheline-adapter port.

---
 rtl/next_line_prefetcher_pkg.sv | 22 ++
 rtl/next_line_prefetcher_pf_trigger_queue.sv | 39 +++
 rtl/next_line_prefetcher.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/next_line_prefetcher_pkg.sv
// Shared types and constants for the next-line prefetcher.
package next_line_prefetcher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    PRESENT
  } pf_state_t;

  localparam int unsigned LINE_BYTES = 32;
  localparam int unsigned LINE_BITS  = 256;

  // A wrap past 2**32 always counts as a crossing.
  function automatic logic line_crosses_page(input logic [31:0] addr,
                                             input int unsigned page_bits);
    logic [32:0] sum;
    sum = {1'b0, addr} + 33'(LINE_BYTES);
    return sum[32] || ((sum[31:0] >> page_bits) != (addr >> page_bits));
  endfunction

endpackage

// File: rtl/next_line_prefetcher_pf_trigger_queue.sv
// One-entry pending-trigger register; a newer push overwrites, clear wins over push.
module pf_trigger_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic        clr,
  output logic        valid,
  output logic [31:0] addr
);

  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (push) begin
      valid_d = 1'b1;
      addr_d  = push_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;

endmodule

// File: rtl/next_line_prefetcher.sv
// Next-line prefetch engine: on a demand-miss trigger, fetches the following
// PF_DEGREE lines within the page and presents each to the cache until acked.
module next_line_prefetcher
  import next_line_prefetcher_pkg::*;
#(
  parameter int unsigned PF_DEGREE = 2,
  parameter int unsigned PAGE_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic [31:0]          cacheline_address,
  input  logic                 pf_ack,
  output logic                 pf_pmem_read,
  output logic [31:0]          pf_pmem_address,
  input  logic                 pf_pmem_resp,
  input  logic [LINE_BITS-1:0] pf_pmem_rdata,
  output logic                 prefetch_ready,
  output logic [31:0]          pf_cline_address,
  output logic [LINE_BITS-1:0] prefetch_rdata,
  output logic [31:0]          pf_issued_count
);

  pf_state_t            state_q, state_d;
  logic [31:0]          next_q, next_d;
  logic [2:0]           remaining_q, remaining_d;
  logic [31:0]          last_addr_q, last_addr_d;
  logic                 last_valid_q, last_valid_d;
  logic                 read_q, read_d;
  logic [31:0]          paddr_q, paddr_d;
  logic                 ready_q, ready_d;
  logic [31:0]          cline_q, cline_d;
  logic [LINE_BITS-1:0] rdata_q, rdata_d;
  logic [31:0]          count_q, count_d;

  logic        pend_valid;
  logic [31:0] pend_addr;
  logic        pend_clr;

  logic        start_valid, start_suppr, cmp_valid;
  logic [31:0] start_base, start_next, cmp_addr;

  assign pend_clr = (state_q == PRESENT) && pf_ack;

  pf_trigger_queue u_pend (
    .clk       (clk),
    .rst       (rst),
    .push      (trigger && (state_q != IDLE)),
    .push_addr (cacheline_address),
    .clr       (pend_clr),
    .valid     (pend_valid),
    .addr      (pend_addr)
  );

  // A same-cycle trigger on the ack cycle bypasses the pending register.
  always_comb begin
    start_valid = trigger || ((state_q != IDLE) && pend_valid);
    start_base  = (trigger || state_q == IDLE) ? cacheline_address : pend_addr;
    start_next  = start_base + 32'(LINE_BYTES);
    cmp_valid   = (state_q == PRESENT) ? 1'b1 : last_valid_q;
    cmp_addr    = (state_q == PRESENT) ? cline_q : last_addr_q;
    start_suppr = line_crosses_page(start_base, PAGE_BITS) ||
                  (cmp_valid && (start_next == cmp_addr));
  end

  always_comb begin
    state_d      = state_q;
    next_d       = next_q;
    remaining_d  = remaining_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
    read_d       = read_q;
    paddr_d      = paddr_q;
    ready_d      = ready_q;
    cline_d      = cline_q;
    rdata_d      = rdata_q;
    count_d      = count_q;
    unique case (state_q)
      IDLE: begin
        if (trigger && !start_suppr) begin
          next_d      = start_next;
          paddr_d     = start_next;
          remaining_d = 3'(PF_DEGREE);
          read_d      = 1'b1;
          state_d     = REQ;
        end
      end
      REQ, WAIT: begin
        if (pf_pmem_resp) begin
          rdata_d = pf_pmem_rdata;
          cline_d = next_q;
          ready_d = 1'b1;
          read_d  = 1'b0;
          if (count_q != '1) count_d = count_q + 32'd1;
          state_d = PRESENT;
        end else begin
          state_d = WAIT;
        end
      end
      PRESENT: begin
        if (pf_ack) begin
          ready_d      = 1'b0;
          last_addr_d  = cline_q;
          last_valid_d = 1'b1;
          remaining_d  = remaining_q - 3'd1;
          if (start_valid) begin
            if (start_suppr) begin
              state_d = IDLE;
            end else begin
              next_d      = start_next;
              paddr_d     = start_next;
              remaining_d = 3'(PF_DEGREE);
              read_d      = 1'b1;
              state_d     = REQ;
            end
          end else if (remaining_q == 3'd1 || line_crosses_page(next_q, PAGE_BITS)) begin
            state_d = IDLE;
          end else begin
            next_d  = next_q + 32'(LINE_BYTES);
            paddr_d = next_q + 32'(LINE_BYTES);
            read_d  = 1'b1;
            state_d = REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      next_q       <= '0;
      remaining_q  <= '0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
      read_q       <= 1'b0;
      paddr_q      <= '0;
      ready_q      <= 1'b0;
      cline_q      <= '0;
      rdata_q      <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      next_q       <= next_d;
      remaining_q  <= remaining_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
      read_q       <= read_d;
      paddr_q      <= paddr_d;
      ready_q      <= ready_d;
      cline_q      <= cline_d;
      rdata_q      <= rdata_d;
      count_q      <= count_d;
    end
  end

  assign pf_pmem_read     = read_q;
  assign pf_pmem_address  = paddr_q;
  assign prefetch_ready   = ready_q;
  assign pf_cline_address = cline_q;
  assign prefetch_rdata   = rdata_q;
  assign pf_issued_count  = count_q;

endmodule
